// File: rtl/wm_pkg.sv
// Shared configuration for the watermark extraction datapath: image geometry,
// derived tile/address widths and the sequencer state encoding.
package wm_pkg;

   localparam int unsigned IMG_W   = 512;
   localparam int unsigned IMG_H   = 512;
   localparam int unsigned BLK     = 8;
   localparam int unsigned TIMEOUT = 1024;

   localparam int unsigned NBX    = IMG_W / BLK;
   localparam int unsigned NBY    = IMG_H / BLK;
   localparam int unsigned NBLK   = NBX * NBY;
   localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
   localparam int unsigned WM_AW  = $clog2(NBLK);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StStore,
      StFin,
      StErr
   } wm_state_e;

   // Counter width that never collapses to zero bits for a count of one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wm_block_sequencer_if.sv
// System/core/watermark-memory signal bundle of the block sequencer.
// slave is the sequencer side; master is the system/core/memory side.
interface wm_block_sequencer_if #(
   parameter int unsigned AddrW = wm_pkg::ADDR_W,
   parameter int unsigned WmAw  = wm_pkg::WM_AW
);

   logic             start;
   logic             abort;
   logic             busy;
   logic             done;
   logic             error;
   logic             core_start;
   logic [AddrW-1:0] core_base_addr;
   logic             core_done;
   logic             core_bit;
   logic             wm_we;
   logic [WmAw-1:0]  wm_addr;
   logic             wm_data;

   modport slave (
      input  start, abort, core_done, core_bit,
      output busy, done, error, core_start, core_base_addr, wm_we, wm_addr, wm_data
   );

   modport master (
      output start, abort, core_done, core_bit,
      input  busy, done, error, core_start, core_base_addr, wm_we, wm_addr, wm_data
   );

endinterface

// File: rtl/wm_tile_counter.sv
// Raster-order tile walker: tile coordinates, linear tile index, registered
// top-left pixel address of the current tile and a last-tile flag.
module wm_tile_counter
   import wm_pkg::*;
#(
   parameter int unsigned ImgW  = IMG_W,
   parameter int unsigned ImgH  = IMG_H,
   parameter int unsigned Blk   = BLK,
   parameter int unsigned Nbx   = ImgW / Blk,
   parameter int unsigned Nby   = ImgH / Blk,
   parameter int unsigned AddrW = $clog2(ImgW * ImgH),
   parameter int unsigned WmAw  = cnt_width(Nbx * Nby),
   parameter int unsigned BxW   = cnt_width(Nbx),
   parameter int unsigned ByW   = cnt_width(Nby)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             adv_i,
   output logic [BxW-1:0]   bx_o,
   output logic [ByW-1:0]   by_o,
   output logic [WmAw-1:0]  idx_o,
   output logic [AddrW-1:0] base_o,
   output logic             last_o
);

   logic [BxW-1:0]   bx_q, bx_d;
   logic [ByW-1:0]   by_q, by_d;
   logic [WmAw-1:0]  idx_q, idx_d;
   logic [AddrW-1:0] base_q, base_d;

   always_comb begin
      bx_d  = bx_q;
      by_d  = by_q;
      idx_d = idx_q;
      if (clr_i) begin
         bx_d  = '0;
         by_d  = '0;
         idx_d = '0;
      end else if (adv_i) begin
         idx_d = idx_q + WmAw'(1);
         if (bx_q == BxW'(Nbx - 1)) begin
            bx_d = '0;
            by_d = by_q + ByW'(1);
         end else begin
            bx_d = bx_q + BxW'(1);
         end
      end
      // Address follows the next coordinates so it is valid as soon as the tile is.
      base_d = AddrW'(by_d) * AddrW'(Blk * ImgW) + AddrW'(bx_d) * AddrW'(Blk);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bx_q   <= '0;
         by_q   <= '0;
         idx_q  <= '0;
         base_q <= '0;
      end else begin
         bx_q   <= bx_d;
         by_q   <= by_d;
         idx_q  <= idx_d;
         base_q <= base_d;
      end
   end

   assign bx_o   = bx_q;
   assign by_o   = by_q;
   assign idx_o  = idx_q;
   assign base_o = base_q;
   assign last_o = (idx_q == WmAw'(Nbx * Nby - 1));

endmodule

// File: rtl/wm_block_sequencer.sv
// Watermark extraction top-level controller: launches the per-tile core in raster
// order, stores each recovered bit, and reports done/error with timeout and abort.
module wm_block_sequencer
   import wm_pkg::*;
#(
   parameter int unsigned ImgW    = IMG_W,
   parameter int unsigned ImgH    = IMG_H,
   parameter int unsigned Blk     = BLK,
   parameter int unsigned Timeout = TIMEOUT
) (
   input logic                 clk,
   input logic                 rst_n,
   wm_block_sequencer_if.slave bus
);

   localparam int unsigned Nbx   = ImgW / Blk;
   localparam int unsigned Nby   = ImgH / Blk;
   localparam int unsigned AddrW = $clog2(ImgW * ImgH);
   localparam int unsigned WmAw  = cnt_width(Nbx * Nby);
   localparam int unsigned BxW   = cnt_width(Nbx);
   localparam int unsigned ByW   = cnt_width(Nby);
   localparam int unsigned ToW   = cnt_width(Timeout);

   wm_state_e        state_q, state_d;
   logic [ToW-1:0]   to_q, to_d;
   logic             bit_q, bit_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             cnt_clr, cnt_adv;
   logic             core_start, wm_we;
   logic [BxW-1:0]   tile_bx;
   logic [ByW-1:0]   tile_by;
   logic [WmAw-1:0]  tile_idx;
   logic [AddrW-1:0] tile_base;
   logic             tile_last;

   wm_tile_counter #(
      .ImgW (ImgW),
      .ImgH (ImgH),
      .Blk  (Blk)
   ) u_tile_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .adv_i  (cnt_adv),
      .bx_o   (tile_bx),
      .by_o   (tile_by),
      .idx_o  (tile_idx),
      .base_o (tile_base),
      .last_o (tile_last)
   );

   always_comb begin
      state_d    = state_q;
      to_d       = to_q;
      bit_d      = bit_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      cnt_clr    = 1'b0;
      cnt_adv    = 1'b0;
      core_start = 1'b0;
      wm_we      = 1'b0;

      // Abort outranks core_done, timeout and the STORE write.
      if ((state_q != StIdle) && bus.abort) begin
         state_d = StIdle;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         error_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_d = StIssue;
                  cnt_clr = 1'b1;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  error_d = 1'b0;
               end
            end
            StIssue: begin
               core_start = 1'b1;
               to_d       = '0;
               state_d    = StWait;
            end
            StWait: begin
               if (bus.core_done) begin
                  bit_d   = bus.core_bit;
                  state_d = StStore;
               end else if (to_q == ToW'(Timeout - 1)) begin
                  state_d = StErr;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  to_d = to_q + ToW'(1);
               end
            end
            StStore: begin
               wm_we = 1'b1;
               if (tile_last) begin
                  state_d = StFin;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_adv = 1'b1;
                  state_d = StIssue;
               end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         to_q    <= '0;
         bit_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         bit_q   <= bit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.error          = error_q;
   assign bus.core_start     = core_start;
   assign bus.core_base_addr = tile_base;
   assign bus.wm_we          = wm_we;
   assign bus.wm_addr        = tile_idx;
   assign bus.wm_data        = bit_q;

   tile_idx_consistent_a : assert property (@(posedge clk) disable iff (!rst_n)
      int'(tile_idx) == int'(tile_by) * int'(Nbx) + int'(tile_bx));

endmodule

// File: tb/tb_wm_block_sequencer.sv
// Scoreboard bench for wm_block_sequencer on a 64x64 image, 8x8 tiles, timeout 16.
module tb_wm_block_sequencer;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_err;
   int   n_writes;
   int   cs_idx;
   int   last_cs_cyc;
   int   mute_tile;
   logic model_done, model_bit, poke_done, poke_bit;

   logic [6:0]  exp_wr_q[$];   // {data, addr}
   logic [11:0] exp_base_q[$];

   wm_block_sequencer_if #(.AddrW(12), .WmAw(6)) bus ();

   wm_block_sequencer #(
      .ImgW    (64),
      .ImgH    (64),
      .Blk     (8),
      .Timeout (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.core_done = model_done | poke_done;
   assign bus.core_bit  = poke_done ? poke_bit : model_bit;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_pass(input int n_wr, input int n_cs);
      for (int i = 0; i < n_cs; i++) exp_base_q.push_back(12'((i / 8) * 512 + (i % 8) * 8));
      for (int i = 0; i < n_wr; i++) exp_wr_q.push_back({i[0], i[5:0]});
   endtask

   task automatic pulse(input int which);
      @(posedge clk);
      #1;
      if (which == 0) bus.start = 1'b1; else bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus.done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("done_timeout", 0, 1);
   endtask

   // Core model: answers 3 cycles after core_start with bit = tile index LSB.
   initial begin
      int tile;
      model_done = 1'b0;
      model_bit  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.core_start) begin
            tile = int'(bus.core_base_addr) / 512 * 8 + (int'(bus.core_base_addr) % 64) / 8;
            if (tile != mute_tile) begin
               repeat (3) @(posedge clk);
               #1;
               model_done = 1'b1;
               model_bit  = tile[0];
               @(posedge clk);
               #1;
               model_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT launches a tile or writes a bit.
   initial begin
      logic [6:0]  e;
      logic [11:0] b;
      forever begin
         @(negedge clk);
         if (rst_n && bus.core_start) begin
            last_cs_cyc = cyc;
            if (exp_base_q.size() == 0) begin
               check("unexpected_core_start", int'(bus.core_base_addr), -1);
            end else begin
               b = exp_base_q.pop_front();
               check("core_base_addr", int'(bus.core_base_addr), int'(b));
            end
            if (cs_idx == 8)  check("base_tile8", int'(bus.core_base_addr), 512);
            if (cs_idx == 63) check("base_tile63", int'(bus.core_base_addr), 3640);
            cs_idx++;
         end
         if (rst_n && bus.wm_we) begin
            n_writes++;
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", int'(bus.wm_addr), -1);
            end else begin
               e = exp_wr_q.pop_front();
               check("wm_addr", int'(bus.wm_addr), int'(e[5:0]));
               check("wm_data", int'(bus.wm_data), int'(e[6]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int wr0;
      int k;
      n_vec = 0; n_err = 0; n_writes = 0; cs_idx = 0; cyc = 0; last_cs_cyc = 0;
      mute_tile = -1;
      poke_done = 1'b0; poke_bit = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_flags", int'({bus.busy, bus.done, bus.error, bus.core_start, bus.wm_we,
                                 bus.wm_data}), 0);
      check("reset_base", int'(bus.core_base_addr), 0);
      check("reset_wm_addr", int'(bus.wm_addr), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full pass with a second start mid-pass; then core_done poked in IDLE.
      push_pass(64, 64);
      cs_idx = 0; wr0 = n_writes;
      pulse(0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("busy_mid_pass", int'(bus.busy), 1);
      pulse(0);
      wait_done(1000, at);
      check("pass1_done", int'(bus.done), 1);
      check("pass1_error", int'(bus.error), 0);
      check("pass1_busy", int'(bus.busy), 0);
      check("pass1_writes", n_writes - wr0, 64);
      check("pass1_queues", exp_wr_q.size() + exp_base_q.size(), 0);
      wr0 = n_writes;
      @(posedge clk);
      #1 poke_done = 1'b1; poke_bit = 1'b1;
      @(posedge clk);
      #1 poke_done = 1'b0;
      pulse(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_core_done_writes", n_writes - wr0, 0);
      check("idle_abort_done_held", int'(bus.done), 1);

      // Timeout on tile 5.
      mute_tile = 5;
      push_pass(5, 6);
      cs_idx = 0; wr0 = n_writes;
      pulse(0);
      wait_done(500, at);
      check("to_done", int'(bus.done), 1);
      check("to_error", int'(bus.error), 1);
      check("to_busy", int'(bus.busy), 0);
      check("to_writes", n_writes - wr0, 5);
      check("to_latency", at - last_cs_cyc, 17);
      check("to_queues", exp_wr_q.size() + exp_base_q.size(), 0);
      mute_tile = -1;

      // Abort during WAIT of tile 10.
      push_pass(10, 11);
      cs_idx = 0; wr0 = n_writes;
      pulse(0);
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         #1;
         if (cs_idx == 11) break;
      end
      check("abort_reached_tile10", cs_idx, 11);
      pulse(1);
      @(negedge clk);
      check("abort_flags", int'({bus.busy, bus.done, bus.error}), 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("abort_writes", n_writes - wr0, 10);
      check("abort_queues", exp_wr_q.size() + exp_base_q.size(), 0);

      // Restart from tile 0, then reset while in STORE of tile 3.
      push_pass(3, 4);
      cs_idx = 0; wr0 = n_writes;
      pulse(0);
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.core_done && bus.core_base_addr == 12'd24) break;
      end
      @(posedge clk);
      #1;
      check("store_we_before_reset", int'(bus.wm_we), 1);
      check("store_addr_before_reset", int'(bus.wm_addr), 3);
      #1 rst_n = 1'b0;
      #1;
      check("rst_store_flags", int'({bus.busy, bus.done, bus.error, bus.core_start, bus.wm_we,
                                     bus.wm_data}), 0);
      check("rst_store_base", int'(bus.core_base_addr), 0);
      check("rst_store_addr", int'(bus.wm_addr), 0);
      @(negedge clk);
      check("rst_writes", n_writes - wr0, 3);
      check("rst_queues", exp_wr_q.size() + exp_base_q.size(), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("post_reset_idle", int'({bus.busy, bus.done, bus.error, bus.wm_we}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
